// File: rtl/alu_seq.sv
// Registered 4-bit-opcode ALU with iterative shifts and a shift-add multiplier behind a start/busy/done handshake.
// Single-cycle ops complete in 1 cycle; shifts in k+1 cycles; MUL in WIDTH+1 cycles. start is ignored while busy.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter int SHW    = $clog2(WIDTH),
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] arg2,
  input  logic [4:0]       in_flg,
  input  logic             block_cy_ov,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [4:0]       out_flg
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_PA1 = 4'b0110;
  localparam logic [3:0] OP_PA2 = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_SAR = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] mc_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] hi_q;
  logic [CW-1:0]    cnt_q;
  logic             blk_q;
  logic             cyin_q;
  logic             ovin_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q;
  logic [4:0]       flg_q;

  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             one_multi_d;
  logic             one_cy_d;
  logic             one_ov_d;
  logic [WIDTH-1:0] one_res_d;
  logic [4:0]       one_flg_d;

  logic [WIDTH:0]   madd;
  logic [WIDTH-1:0] step_acc_d;
  logic [WIDTH-1:0] step_hi_d;
  logic             step_cy_d;
  logic             step_ov_d;
  logic [4:0]       step_flg_d;

  // Only CY and OV of the incoming flag bus feed the datapath.
  logic unused_flg;
  assign unused_flg = ^{in_flg[4], in_flg[2:1]};

  function automatic logic [4:0] mk_flags(input logic [WIDTH-1:0] r, input logic cy, input logic ov,
                                          input logic blk, input logic cyi, input logic ovi);
    mk_flags = {~|r, blk ? cyi : cy, r[WIDTH-1], ^r, blk ? ovi : ov};
  endfunction

  always_comb begin
    cin         = block_cy_ov & in_flg[3];
    sum         = {1'b0, arg1} + {1'b0, arg2} + {{WIDTH{1'b0}}, cin};
    dif         = {1'b0, arg1} - {1'b0, arg2} - {{WIDTH{1'b0}}, cin};
    one_res_d   = arg2;
    one_cy_d    = 1'b0;
    one_ov_d    = 1'b0;
    one_multi_d = 1'b0;
    case (opcode)
      OP_ADD: begin
        one_res_d = sum[WIDTH-1:0];
        one_cy_d  = sum[WIDTH];
        one_ov_d  = (arg1[WIDTH-1] == arg2[WIDTH-1]) && (sum[WIDTH-1] != arg1[WIDTH-1]);
      end
      OP_SUB: begin
        one_res_d = dif[WIDTH-1:0];
        one_cy_d  = dif[WIDTH];
        one_ov_d  = (arg1[WIDTH-1] != arg2[WIDTH-1]) && (dif[WIDTH-1] != arg1[WIDTH-1]);
      end
      OP_AND: one_res_d = arg1 & arg2;
      OP_OR:  one_res_d = arg1 | arg2;
      OP_XOR: one_res_d = arg1 ^ arg2;
      OP_NOT: one_res_d = ~arg1;
      OP_PA1: one_res_d = arg1;
      OP_PA2: one_res_d = arg2;
      // A zero-count shift completes immediately with the operand unchanged.
      OP_SHL, OP_SHR, OP_SAR: begin
        one_res_d   = arg1;
        one_multi_d = (arg2[SHW-1:0] != '0);
      end
      OP_MUL: one_multi_d = (MUL_EN != 0);
      default: one_res_d = arg2;
    endcase
    one_flg_d = mk_flags(one_res_d, one_cy_d, one_ov_d, block_cy_ov, in_flg[3], in_flg[0]);
  end

  // One iteration: shifts move acc by one bit; MUL adds the multiplicand into the
  // high half when the multiplier LSB is set, then shifts {hi,acc} right.
  always_comb begin
    madd       = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mc_q} : {(WIDTH+1){1'b0}});
    step_hi_d  = hi_q;
    step_ov_d  = 1'b0;
    case (op_q)
      OP_SHL: begin
        step_acc_d = {acc_q[WIDTH-2:0], 1'b0};
        step_cy_d  = acc_q[WIDTH-1];
      end
      OP_SHR: begin
        step_acc_d = {1'b0, acc_q[WIDTH-1:1]};
        step_cy_d  = acc_q[0];
      end
      OP_SAR: begin
        step_acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        step_cy_d  = acc_q[0];
      end
      default: begin
        step_hi_d  = madd[WIDTH:1];
        step_acc_d = {madd[0], acc_q[WIDTH-1:1]};
        step_cy_d  = |madd[WIDTH:1];
        step_ov_d  = |madd[WIDTH:1];
      end
    endcase
    step_flg_d = mk_flags(step_acc_d, step_cy_d, step_ov_d, blk_q, cyin_q, ovin_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      mc_q    <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      blk_q   <= 1'b0;
      cyin_q  <= 1'b0;
      ovin_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= opcode;
            mc_q   <= arg1;
            hi_q   <= '0;
            blk_q  <= block_cy_ov;
            cyin_q <= in_flg[3];
            ovin_q <= in_flg[0];
            if (one_multi_d) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              if (opcode == OP_MUL) begin
                acc_q <= arg2;
                cnt_q <= CW'(WIDTH);
              end else begin
                acc_q <= arg1;
                cnt_q <= CW'(arg2[SHW-1:0]);
              end
            end else begin
              res_q  <= one_res_d;
              flg_q  <= one_flg_d;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_q <= step_acc_d;
          hi_q  <= step_hi_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            res_q   <= step_acc_d;
            flg_q   <= step_flg_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign res     = res_q;
  assign out_flg = flg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [15:0] arg1 = '0;
  logic [15:0] arg2 = '0;
  logic [4:0]  in_flg = '0;
  logic        block_cy_ov = 1'b0;
  logic        busy, done;
  logic [15:0] res;
  logic [4:0]  out_flg;

  int n_checks = 0;
  int n_pass = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .arg1(arg1), .arg2(arg2),
    .in_flg(in_flg), .block_cy_ov(block_cy_ov), .busy(busy), .done(done), .res(res), .out_flg(out_flg)
  );

  always #5 clk = ~clk;

  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] fi, input logic blk,
                       output logic [15:0] r, output logic [4:0] f, output int lat);
    int k, cin, t, sa, sb, sr;
    longint p;
    logic cy, ov;
    k = int'(b) % 16;
    cin = (blk && fi[3]) ? 1 : 0;
    sa = $signed(a);
    sb = $signed(b);
    cy = 1'b0; ov = 1'b0; lat = 1; r = b;
    case (op)
      4'd0: begin
        t = int'(a) + int'(b) + cin; r = t[15:0]; cy = t[16];
        sr = sa + sb + cin; ov = (sr > 32767) || (sr < -32768);
      end
      4'd1: begin
        t = int'(a) - int'(b) - cin; r = t[15:0]; cy = (t < 0);
        sr = sa - sb - cin; ov = (sr > 32767) || (sr < -32768);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a;
      4'd7: r = b;
      4'd8: begin t = int'(a) << k; r = t[15:0]; cy = (k != 0) && t[16]; lat = k + 1; end
      4'd9: begin r = a >> k; if (k != 0) cy = a[k-1]; lat = k + 1; end
      4'd10: begin
        t = sa >>> k; r = t[15:0];
        if (k != 0) begin t = sa >>> (k - 1); cy = t[0]; end
        lat = k + 1;
      end
      4'd11: begin p = longint'(a) * longint'(b); r = p[15:0]; cy = (p[31:16] != 0); ov = cy; lat = 17; end
      default: r = b;
    endcase
    if (blk) begin cy = fi[3]; ov = fi[0]; end
    f = {r == 16'h0, cy, r[15], ($countones(r) % 2) == 1, ov};
  endtask

  // Issue one operation and wait (bounded) for done; optionally pulse start while busy.
  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] fi, input logic blk, input bit noise,
                       output logic [15:0] r, output logic [4:0] f, output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1; opcode = op; arg1 = a; arg2 = b; in_flg = fi; block_cy_ov = blk;
    @(negedge clk);
    start = 1'b0; lat = 1; nbusy = 0;
    arg1 = 16'($urandom); arg2 = 16'($urandom); opcode = 4'($urandom); in_flg = 5'($urandom);
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (noise) start = busy & 1'($urandom_range(0, 1));
      arg1 = 16'($urandom); arg2 = 16'($urandom); opcode = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    r = res; f = out_flg;
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (res !== 16'h0) $display("FAIL reset_res: got %h want 0000", res); else n_pass++;
    n_checks++; if (out_flg !== 5'b0) $display("FAIL reset_flg: got %b want 00000", out_flg); else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL idle_no_done: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_directed;
    logic [15:0] r; logic [4:0] f; int lat, nb;
    do_op(4'd0, 16'h7FFF, 16'h0001, 5'b0, 1'b0, 1'b0, r, f, lat, nb);
    n_checks++; if (r !== 16'h8000 || f !== 5'b00111 || lat !== 1)
      $display("FAIL add_ovf: res=%h flg=%b lat=%0d want 8000 00111 1", r, f, lat); else n_pass++;
    do_op(4'd0, 16'h00FF, 16'h0001, 5'b01001, 1'b1, 1'b0, r, f, lat, nb);
    n_checks++; if (r !== 16'h0101 || f !== 5'b01001 || lat !== 1)
      $display("FAIL add_block: res=%h flg=%b lat=%0d want 0101 01001 1", r, f, lat); else n_pass++;
    do_op(4'd8, 16'h8001, 16'h0001, 5'b0, 1'b0, 1'b0, r, f, lat, nb);
    n_checks++; if (r !== 16'h0002 || f !== 5'b01010 || lat !== 2)
      $display("FAIL shl1: res=%h flg=%b lat=%0d want 0002 01010 2", r, f, lat); else n_pass++;
    do_op(4'd8, 16'h8001, 16'h0000, 5'b0, 1'b0, 1'b0, r, f, lat, nb);
    n_checks++; if (r !== 16'h8001 || f !== 5'b00100 || lat !== 1)
      $display("FAIL shl0: res=%h flg=%b lat=%0d want 8001 00100 1", r, f, lat); else n_pass++;
    do_op(4'd10, 16'h8000, 16'h000F, 5'b0, 1'b0, 1'b0, r, f, lat, nb);
    n_checks++; if (r !== 16'hFFFF || f !== 5'b00100 || lat !== 16)
      $display("FAIL sar15: res=%h flg=%b lat=%0d want ffff 00100 16", r, f, lat); else n_pass++;
    do_op(4'd11, 16'h0100, 16'h0100, 5'b0, 1'b0, 1'b0, r, f, lat, nb);
    n_checks++; if (r !== 16'h0000 || f !== 5'b11001 || lat !== 17)
      $display("FAIL mul: res=%h flg=%b lat=%0d want 0000 11001 17", r, f, lat); else n_pass++;
    n_checks++; if (nb !== 16) $display("FAIL mul_busy: got %0d busy cycles want 16", nb); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] er, a, b; logic [4:0] ef, fi; logic [3:0] op; logic blk; int el;
    @(negedge clk);
    start = 1'b1; opcode = 4'd1; arg1 = 16'h0000; arg2 = 16'h0001; in_flg = 5'b0; block_cy_ov = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || res !== 16'hFFFF || out_flg !== 5'b01100)
      $display("FAIL b2b_sub: done=%b res=%h flg=%b want 1 ffff 01100", done, res, out_flg); else n_pass++;
    opcode = 4'd0; arg1 = 16'h7FFF; arg2 = 16'h0001;
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || res !== 16'h8000 || out_flg !== 5'b00111)
      $display("FAIL b2b_add: done=%b res=%h flg=%b want 1 8000 00111", done, res, out_flg); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 7));
      if (i % 4 == 3) op = 4'($urandom_range(12, 15));
      a = 16'($urandom); b = 16'($urandom); fi = 5'($urandom); blk = 1'($urandom);
      if (i % 5 == 4) begin op = 4'($urandom_range(8, 10)); b[3:0] = 4'h0; end
      model(op, a, b, fi, blk, er, ef, el);
      opcode = op; arg1 = a; arg2 = b; in_flg = fi; block_cy_ov = blk;
      @(negedge clk);
      n_checks++; if (done !== 1'b1 || res !== er || out_flg !== ef)
        $display("FAIL b2b_rand%0d: op=%0d done=%b res=%h flg=%b want 1 %h %b", i, op, done, res, out_flg, er, ef);
      else n_pass++;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    logic [15:0] r, er; logic [4:0] f, ef; int lat, el, nb, extra;
    model(4'd11, 16'h0100, 16'h0100, 5'b0, 1'b0, er, ef, el);
    do_op(4'd11, 16'h0100, 16'h0100, 5'b0, 1'b0, 1'b1, r, f, lat, nb);
    n_checks++; if (r !== er || f !== ef || lat !== el)
      $display("FAIL mul_noise: res=%h flg=%b lat=%0d want %h %b %0d", r, f, lat, er, ef, el); else n_pass++;
    extra = 0;
    repeat (20) begin @(negedge clk); if (done) extra++; end
    n_checks++; if (extra !== 0) $display("FAIL single_done: got %0d extra done want 0", extra); else n_pass++;
  endtask

  task automatic test_random;
    logic [15:0] r, er, a, b; logic [4:0] f, ef, fi; logic [3:0] op; logic blk; int lat, el, nb;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = 16'($urandom); b = 16'($urandom); fi = 5'($urandom);
      blk = ($urandom_range(0, 3) == 0);
      model(op, a, b, fi, blk, er, ef, el);
      do_op(op, a, b, fi, blk, 1'b1, r, f, lat, nb);
      n_checks++; if (r !== er || f !== ef || lat !== el)
        $display("FAIL rand%0d: op=%0d a=%h b=%h res=%h flg=%b lat=%0d want %h %b %0d",
                 i, op, a, b, r, f, lat, er, ef, el);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] r, er; logic [4:0] f, ef; int lat, el, nb, nd;
    do_op(4'd0, 16'h0001, 16'h0001, 5'b0, 1'b0, 1'b0, r, f, lat, nb);
    @(negedge clk);
    start = 1'b1; opcode = 4'd11; arg1 = 16'h0003; arg2 = 16'h0005; block_cy_ov = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || res !== 16'h0 || out_flg !== 5'b0)
      $display("FAIL mid_reset: busy=%b done=%b res=%h flg=%b want 0 0 0000 00000", busy, done, res, out_flg);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (25) begin @(negedge clk); if (done) nd++; end
    n_checks++; if (nd !== 0) $display("FAIL abort_no_done: got %0d done want 0", nd); else n_pass++;
    model(4'd0, 16'h1234, 16'h1111, 5'b0, 1'b0, er, ef, el);
    do_op(4'd0, 16'h1234, 16'h1111, 5'b0, 1'b0, 1'b0, r, f, lat, nb);
    n_checks++; if (r !== er || f !== ef || lat !== el)
      $display("FAIL post_reset_add: res=%h flg=%b lat=%0d want %h %b %0d", r, f, lat, er, ef, el); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
